alu_multicycle: RTL and testbench

//   Parametrised multi-cycle ALU for the next-generation (multi-cycle/pipelined) MIPS datapath.

---
 rtl/alu_multicycle.sv | 201 ++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes, an iterative shift-add multiplier and,
// when ALU_DIV_EN is defined, an iterative unsigned restoring divider.
module alu_multicycle #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALU_FUNC,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] ALU_OUT,
   output logic [WIDTH-1:0] ALU_HI,
   output logic             Zero_Flag,
   output logic             Div0_Flag
);

   localparam logic [2:0] FN_AND  = 3'b000;
   localparam logic [2:0] FN_OR   = 3'b001;
   localparam logic [2:0] FN_ADD  = 3'b010;
   localparam logic [2:0] FN_SLTS = 3'b011;
   localparam logic [2:0] FN_SUB  = 3'b100;
   localparam logic [2:0] FN_MUL  = 3'b101;
   localparam logic [2:0] FN_SLT  = 3'b110;
`ifdef ALU_DIV_EN
   localparam logic [2:0] FN_DIV  = 3'b111;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
`ifdef ALU_DIV_EN
      S_DIV  = 2'd2,
`endif
      S_DONE = 2'd3
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] count, count_next;
   logic [WIDTH-1:0] op_reg, op_next;
   logic [WIDTH-1:0] work_hi, work_hi_next;
   logic [WIDTH-1:0] work_lo, work_lo_next;
   logic [WIDTH-1:0] out_reg, out_next;
   logic [WIDTH-1:0] hi_reg, hi_next;
   logic [WIDTH-1:0] single_res;
   logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
   logic             div0_reg, div0_next;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] div_rem;
   logic [WIDTH-1:0] div_quo;
`endif

   // Result of every single-cycle operation, taken straight from the inputs at accept.
   always_comb begin
      single_res = '0;
      case (ALU_FUNC)
         FN_AND:  single_res = A & B;
         FN_OR:   single_res = A | B;
         FN_ADD:  single_res = A + B;
         FN_SUB:  single_res = A - B;
         FN_SLT:  single_res = {{(WIDTH-1){1'b0}}, (A < B)};
         FN_SLTS: single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         default: single_res = '0;
      endcase
   end

   // Multiplier step: {work_hi, work_lo} holds the partial product with the
   // unconsumed multiplier bits in the low half; add then shift right by one.
   assign mul_sum = {1'b0, work_hi} + {1'b0, (work_lo[0] ? op_reg : {WIDTH{1'b0}})};

`ifdef ALU_DIV_EN
   // Restoring divider step: work_hi is the remainder, work_lo shifts the dividend
   // out at the top and collects quotient bits at the bottom. A zero divisor
   // naturally yields an all-ones quotient and a remainder equal to the dividend.
   assign div_shift = {work_hi, work_lo[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, op_reg});
   assign div_diff  = div_shift - {1'b0, op_reg};
   assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign div_quo   = {work_lo[WIDTH-2:0], div_ge};
`endif

   // Next-state, iteration and result-write logic.
   always_comb begin
      state_next   = state;
      count_next   = count;
      op_next      = op_reg;
      work_hi_next = work_hi;
      work_lo_next = work_lo;
      out_next     = out_reg;
      hi_next      = hi_reg;
`ifdef ALU_DIV_EN
      div0_next    = div0_reg;
`endif
      case (state)
         S_IDLE: begin
            if (IN_VALID) begin
               if (ALU_FUNC == FN_MUL) begin
                  op_next      = A;
                  work_hi_next = '0;
                  work_lo_next = B;
                  count_next   = CNT_W'(WIDTH);
                  state_next   = S_MUL;
`ifdef ALU_DIV_EN
               end else if (ALU_FUNC == FN_DIV) begin
                  op_next      = B;
                  work_hi_next = '0;
                  work_lo_next = A;
                  count_next   = CNT_W'(WIDTH);
                  state_next   = S_DIV;
`endif
               end else begin
                  out_next   = single_res;
                  hi_next    = '0;
`ifdef ALU_DIV_EN
                  div0_next  = 1'b0;
`endif
                  state_next = S_DONE;
               end
            end
         end
         S_MUL: begin
            work_hi_next = mul_sum[WIDTH:1];
            work_lo_next = {mul_sum[0], work_lo[WIDTH-1:1]};
            count_next   = count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
               out_next   = {mul_sum[0], work_lo[WIDTH-1:1]};
               hi_next    = mul_sum[WIDTH:1];
`ifdef ALU_DIV_EN
               div0_next  = 1'b0;
`endif
               state_next = S_DONE;
            end
         end
`ifdef ALU_DIV_EN
         S_DIV: begin
            work_hi_next = div_rem;
            work_lo_next = div_quo;
            count_next   = count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
               out_next   = div_quo;
               hi_next    = div_rem;
               div0_next  = (op_reg == '0);
               state_next = S_DONE;
            end
         end
`endif
         S_DONE: begin
            if (OUT_READY) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         count    <= '0;
         op_reg   <= '0;
         work_hi  <= '0;
         work_lo  <= '0;
         out_reg  <= '0;
         hi_reg   <= '0;
`ifdef ALU_DIV_EN
         div0_reg <= 1'b0;
`endif
      end else begin
         state    <= state_next;
         count    <= count_next;
         op_reg   <= op_next;
         work_hi  <= work_hi_next;
         work_lo  <= work_lo_next;
         out_reg  <= out_next;
         hi_reg   <= hi_next;
`ifdef ALU_DIV_EN
         div0_reg <= div0_next;
`endif
      end
   end

   assign IN_READY  = (state == S_IDLE);
   assign OUT_VALID = (state == S_DONE);
   assign ALU_OUT   = out_reg;
   assign ALU_HI    = hi_reg;
   assign Zero_Flag = (out_reg == '0);
`ifdef ALU_DIV_EN
   assign Div0_Flag = div0_reg;
`else
   assign Div0_Flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32); DIV checks follow ALU_DIV_EN.
module tb_alu_multicycle;

   logic        CLK = 1'b0;
   logic        RST;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  ALU_FUNC;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] ALU_OUT;
   logic [31:0] ALU_HI;
   logic        Zero_Flag;
   logic        Div0_Flag;

   int compared   = 0;
   int mismatched = 0;
   int edges;
   int readyLeaks;
   int badCycles;

   alu_multicycle #(.WIDTH(32)) dut (
      .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .A(A), .B(B), .ALU_FUNC(ALU_FUNC), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY), .ALU_OUT(ALU_OUT), .ALU_HI(ALU_HI),
      .Zero_Flag(Zero_Flag), .Div0_Flag(Div0_Flag)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one request for exactly one edge, then scrambles the operands.
   task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      ALU_FUNC = f;
      A        = a;
      B        = b;
      IN_VALID = 1'b1;
      tick;
      IN_VALID = 1'b0;
      A        = 32'hA5A5_5A5A;
      B        = 32'h0000_0003;
      ALU_FUNC = 3'b000;
   endtask

   // Edges are counted including the accept edge; bounded at 100.
   task automatic waitResult(output int n);
      n = 1;
      while (!OUT_VALID && n < 100) begin
         if (IN_READY) readyLeaks++;
         tick;
         n++;
      end
   endtask

   task automatic releaseResult;
      OUT_READY = 1'b1;
      tick;
      OUT_READY = 1'b0;
   endtask

   initial begin
      RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
      A = '0; B = '0; ALU_FUNC = 3'b000;
      repeat (2) tick;
      RST = 1'b0;
      checkOutput("reset IN_READY", IN_READY, 1);
      checkOutput("reset OUT_VALID", OUT_VALID, 0);
      checkOutput("reset Zero_Flag", Zero_Flag, 1);
      checkOutput("reset ALU_OUT", ALU_OUT, 0);
      checkOutput("reset ALU_HI", ALU_HI, 0);
      checkOutput("reset Div0_Flag", Div0_Flag, 0);

      applyStimulus(3'b010, 32'hFFFF_FFFF, 32'h1);
      checkOutput("add latency", OUT_VALID, 1);
      checkOutput("add ALU_OUT", ALU_OUT, 0);
      checkOutput("add Zero_Flag", Zero_Flag, 1);
      checkOutput("add IN_READY", IN_READY, 0);
      releaseResult;
      checkOutput("add release OUT_VALID", OUT_VALID, 0);
      checkOutput("add release IN_READY", IN_READY, 1);

      applyStimulus(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00);
      checkOutput("and ALU_OUT", ALU_OUT, 32'h00F0_1200);
      checkOutput("and Zero_Flag", Zero_Flag, 0);
      releaseResult;

      applyStimulus(3'b001, 32'hF0F0_1234, 32'h0FF0_FF00);
      checkOutput("or ALU_OUT", ALU_OUT, 32'hFFF0_FF34);
      releaseResult;

      applyStimulus(3'b110, 32'hFFFF_FFFF, 32'h1);
      checkOutput("slt ALU_OUT", ALU_OUT, 0);
      checkOutput("slt Zero_Flag", Zero_Flag, 1);
      releaseResult;

      applyStimulus(3'b011, 32'hFFFF_FFFF, 32'h1);
      checkOutput("slts ALU_OUT", ALU_OUT, 1);
      checkOutput("slts Zero_Flag", Zero_Flag, 0);
      releaseResult;

      applyStimulus(3'b100, 32'd5, 32'd7);
      checkOutput("sub ALU_OUT", ALU_OUT, 32'hFFFF_FFFE);
      checkOutput("sub ALU_HI", ALU_HI, 0);
      releaseResult;
      checkOutput("sub result held after release", ALU_OUT, 32'hFFFF_FFFE);

      readyLeaks = 0;
      applyStimulus(3'b101, 32'hFFFF_FFFF, 32'h2);
      checkOutput("mul not valid after accept", OUT_VALID, 0);
      waitResult(edges);
      checkOutput("mul latency edges", edges, 33);
      checkOutput("mul IN_READY low while busy", readyLeaks, 0);
      checkOutput("mul ALU_OUT", ALU_OUT, 32'hFFFF_FFFE);
      checkOutput("mul ALU_HI", ALU_HI, 32'h1);

      badCycles = 0;
      for (int i = 0; i < 10; i++) begin
         ALU_FUNC = 3'b010;
         A        = 32'h1;
         B        = 32'h1;
         IN_VALID = (i % 2 == 0);
         tick;
         if (OUT_VALID !== 1'b1 || ALU_OUT !== 32'hFFFF_FFFE || ALU_HI !== 32'h1 || IN_READY !== 1'b0)
            badCycles++;
      end
      IN_VALID = 1'b0;
      checkOutput("backpressure stable cycles", badCycles, 0);
      releaseResult;
      checkOutput("backpressure release IN_READY", IN_READY, 1);
      checkOutput("backpressure release OUT_VALID", OUT_VALID, 0);

      applyStimulus(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      waitResult(edges);
      checkOutput("mul max latency edges", edges, 33);
      checkOutput("mul max product", {ALU_HI, ALU_OUT}, 64'hFFFF_FFFE_0000_0001);
      releaseResult;

      applyStimulus(3'b101, 32'h1234_5678, 32'h0);
      waitResult(edges);
      checkOutput("mul by zero product", {ALU_HI, ALU_OUT}, 64'h0);
      checkOutput("mul by zero Zero_Flag", Zero_Flag, 1);
      releaseResult;

      applyStimulus(3'b101, 32'd1000, 32'd3000);
      waitResult(edges);
      checkOutput("mul 1000x3000 product", {ALU_HI, ALU_OUT}, 64'd3000000);
      releaseResult;

      applyStimulus(3'b101, 32'd7, 32'd9);
      repeat (9) tick;
      RST = 1'b1;
      tick;
      RST = 1'b0;
      checkOutput("mid-mul reset OUT_VALID", OUT_VALID, 0);
      checkOutput("mid-mul reset IN_READY", IN_READY, 1);
      checkOutput("mid-mul reset ALU_OUT", ALU_OUT, 0);
      badCycles = 0;
      repeat (40) begin
         tick;
         if (OUT_VALID !== 1'b0) badCycles++;
      end
      checkOutput("mid-mul reset no stray result", badCycles, 0);

      applyStimulus(3'b010, 32'd3, 32'd4);
      checkOutput("post-reset add ALU_OUT", ALU_OUT, 32'd7);
      releaseResult;

`ifdef ALU_DIV_EN
      applyStimulus(3'b111, 32'd100, 32'd7);
      waitResult(edges);
      checkOutput("div latency edges", edges, 33);
      checkOutput("div quotient", ALU_OUT, 32'd14);
      checkOutput("div remainder", ALU_HI, 32'd2);
      checkOutput("div Div0_Flag", Div0_Flag, 0);
      releaseResult;

      applyStimulus(3'b111, 32'd5, 32'd0);
      waitResult(edges);
      checkOutput("div0 latency edges", edges, 33);
      checkOutput("div0 quotient", ALU_OUT, 32'hFFFF_FFFF);
      checkOutput("div0 remainder", ALU_HI, 32'd5);
      checkOutput("div0 Div0_Flag", Div0_Flag, 1);
      releaseResult;

      applyStimulus(3'b010, 32'd1, 32'd1);
      checkOutput("add after div0 Div0_Flag", Div0_Flag, 0);
      checkOutput("add after div0 ALU_HI", ALU_HI, 0);
      releaseResult;
`else
      applyStimulus(3'b111, 32'd9, 32'd4);
      checkOutput("undef 111 latency", OUT_VALID, 1);
      checkOutput("undef 111 ALU_OUT", ALU_OUT, 0);
      checkOutput("undef 111 Zero_Flag", Zero_Flag, 1);
      checkOutput("undef 111 ALU_HI", ALU_HI, 0);
      checkOutput("undef 111 Div0_Flag", Div0_Flag, 0);
      releaseResult;

      applyStimulus(3'b111, 32'd3, 32'd3);
      checkOutput("undef 111 A=B=3 ALU_OUT", ALU_OUT, 0);
      releaseResult;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
